// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash target answering JEDEC ID (0x9F), read status (0x05),
// write enable/disable (0x06/0x04) and read data (0x03) from a synchronous byte-wide memory port.
// All SPI pins are oversampled on clk_48mhz through 2-flop synchronizers (f_sck <= clk/8).
// Optional macro FAST_READ_EN adds command 0x0B (read with 8 dummy clocks).
// Ports:
//   clk_48mhz    system clock, rising edge
//   reset        synchronous active-low reset
//   spi_cs       chip select, active low, asynchronous
//   spi_sck      SPI clock, idle low, asynchronous
//   spi_mosi     serial data in
//   spi_miso     serial data out, 0 when not driving
//   spi_miso_oe  pad tristate enable
//   busy         reported as status bit 0 (WIP)
//   mem_addr     memory read address
//   mem_rd_en    one-cycle memory read strobe
//   mem_rd_data  memory data, valid one clock after mem_rd_en
module spi_flash_responder #(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4016
) (
    input  logic                  clk_48mhz,
    input  logic                  reset,
    input  logic                  spi_cs,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [7:0]            mem_rd_data
);
`ifdef FAST_READ_EN
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA_OUT, IGNORE, DUMMY} state_t;
`else
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA_OUT, IGNORE} state_t;
`endif
    typedef enum logic [1:0] {SRC_ID, SRC_STAT, SRC_MEM} src_t;

    logic [2:0]            cs_q, sck_q;
    logic [1:0]            mosi_q;
    state_t                state_q, state_d;
    src_t                  src_q, src_d;
    logic [2:0]            bit_q, bit_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [22:0]           rx_q, rx_d;
    logic [7:0]            cmd_q, cmd_d, sh_q, sh_d;
    logic                  miso_q, miso_d, wel_q, wel_d, extra_q, extra_d;
    logic                  rd_q, rd_d, ld_q, ld_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  cs_hi, sck_rise, sck_fall, byte_done, is_read;
    logic [7:0]            rx_byte, next_byte;

    assign cs_hi     = cs_q[1];
    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign byte_done = sck_rise && bit_q == 3'd7;
    assign rx_byte   = {rx_q[6:0], mosi_q[1]};
`ifdef FAST_READ_EN
    assign is_read   = rx_byte == 8'h03 || rx_byte == 8'h0B;
`else
    assign is_read   = rx_byte == 8'h03;
`endif
    // cnt_q doubles as the ID byte index; it saturates at 3 so 0x00 repeats after the ID
    assign next_byte = src_q == SRC_STAT ? {6'b0, wel_q, busy} :
                       cnt_q == 2'd1 ? JEDEC_ID[15:8] :
                       cnt_q == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
    assign spi_miso_oe = state_q == DATA_OUT && !cs_hi;
    assign spi_miso    = spi_miso_oe & miso_q;
    assign mem_addr    = addr_q;
    assign mem_rd_en   = rd_q;

    always_ff @(posedge clk_48mhz) begin
        if (!reset) begin
            cs_q    <= 3'b111;
            sck_q   <= '0;
            mosi_q  <= '0;
            state_q <= IDLE;
            src_q   <= SRC_ID;
            bit_q   <= '0;
            cnt_q   <= '0;
            rx_q    <= '0;
            cmd_q   <= '0;
            sh_q    <= '0;
            miso_q  <= 1'b0;
            wel_q   <= 1'b0;
            extra_q <= 1'b0;
            rd_q    <= 1'b0;
            ld_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            cs_q    <= {cs_q[1:0], spi_cs};
            sck_q   <= {sck_q[1:0], spi_sck};
            mosi_q  <= {mosi_q[0], spi_mosi};
            state_q <= state_d;
            src_q   <= src_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            cmd_q   <= cmd_d;
            sh_q    <= sh_d;
            miso_q  <= miso_d;
            wel_q   <= wel_d;
            extra_q <= extra_d;
            rd_q    <= rd_d;
            ld_q    <= ld_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        cmd_d   = cmd_q;
        sh_d    = ld_q ? mem_rd_data : sh_q;
        miso_d  = miso_q;
        wel_d   = wel_q;
        extra_d = extra_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        ld_d    = rd_q;
        if (cs_hi) begin
            // cs high overrides everything, including a coincident sck edge
            state_d = IDLE;
            miso_d  = 1'b0;
            if (state_q == IGNORE && !extra_q && bit_q == 3'd0 && (cmd_q == 8'h06 || cmd_q == 8'h04))
                wel_d = cmd_q == 8'h06;
        end else if (state_q == IDLE) begin
            if (cs_q[2]) begin
                state_d = CMD;
                bit_d   = '0;
            end
        end else begin
            if (sck_rise) begin
                bit_d = bit_q + 3'd1;
                rx_d  = {rx_q[21:0], mosi_q[1]};
            end
            if (state_q == IGNORE && sck_rise)
                extra_d = 1'b1;
            if (state_q == DATA_OUT && sck_fall) begin
                miso_d = sh_q[7];
                sh_d   = {sh_q[6:0], 1'b0};
            end
            if (byte_done) begin
                case (state_q)
                    CMD: begin
                        cmd_d   = rx_byte;
                        extra_d = 1'b0;
                        cnt_d   = is_read ? 2'd0 : 2'd1;
                        src_d   = rx_byte == 8'h05 ? SRC_STAT : SRC_ID;
                        sh_d    = rx_byte == 8'h05 ? {6'b0, wel_q, busy} : JEDEC_ID[23:16];
                        state_d = rx_byte == 8'h9F || rx_byte == 8'h05 ? DATA_OUT : is_read ? ADDR : IGNORE;
                    end
                    ADDR: begin
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd2) begin
                            addr_d  = ADDR_WIDTH'({rx_q, mosi_q[1]});
                            state_d = DATA_OUT;
                            src_d   = SRC_MEM;
                            rd_d    = 1'b1;
`ifdef FAST_READ_EN
                            if (cmd_q == 8'h0B) begin
                                state_d = DUMMY;
                                rd_d    = 1'b0;
                            end
`endif
                        end
                    end
`ifdef FAST_READ_EN
                    DUMMY: begin
                        state_d = DATA_OUT;
                        rd_d    = 1'b1;
                    end
`endif
                    DATA_OUT: begin
                        // memory source prefetches the next byte; ID/status load directly
                        if (src_q == SRC_MEM) begin
                            addr_d = addr_q + ADDR_WIDTH'(1);
                            rd_d   = 1'b1;
                        end else begin
                            sh_d  = next_byte;
                            cnt_d = cnt_q == 2'd3 ? cnt_q : cnt_q + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;
    localparam int          AW = 16;
    localparam logic [23:0] ID = 24'hEF4016;

    logic          clk = 1'b0, rst_n = 1'b0, cs = 1'b1, sck = 1'b0, mosi = 1'b0, busy = 1'b0;
    logic          miso, oe, rd_en;
    logic [AW-1:0] addr;
    logic [7:0]    rd_data = 8'h00;

    spi_flash_responder #(.ADDR_WIDTH(AW), .JEDEC_ID(ID)) dut (
        .clk_48mhz(clk), .reset(rst_n), .spi_cs(cs), .spi_sck(sck), .spi_mosi(mosi),
        .spi_miso(miso), .spi_miso_oe(oe), .busy(busy), .mem_addr(addr),
        .mem_rd_en(rd_en), .mem_rd_data(rd_data)
    );

    always #10 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk) if (rd_en) rd_data <= mem[addr];

    int pass_cnt = 0, total_cnt = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    logic [7:0]    tx [0:15];
    logic [7:0]    rx [0:15];
    logic          oe_bits [0:127];
    logic [AW-1:0] exp_addr_q [$];
    logic [7:0]    others [0:4] = '{8'h00, 8'h0B, 8'h02, 8'hFF, 8'h5A};
    int            cs_hi_cnt = 0, rd_cnt = 0, hp = 5;
    bit            mon_en = 0, wel_m = 0;

    // Per-cycle checks: idle miso, released pad after cs rises, strobe addresses
    always @(negedge clk) begin
        cs_hi_cnt = cs ? cs_hi_cnt + 1 : 0;
        if (mon_en) begin
            if (!oe) check("miso_idle", 32'(miso), 32'd0);
            if (cs_hi_cnt >= 4) check("oe_cs_high", 32'(oe), 32'd0);
            if (rd_en) begin
                rd_cnt++;
                check("rd_en_expected", 32'(exp_addr_q.size() > 0), 32'd1);
                if (exp_addr_q.size() > 0) check("mem_addr", 32'(addr), 32'(exp_addr_q.pop_front()));
            end
        end
    end

    task automatic run(input int nbits, input bit cs_on_last);
        @(negedge clk);
        cs = 1'b0;
        repeat (hp) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[i / 8][7 - i % 8];
            repeat (hp) @(negedge clk);
            rx[i / 8][7 - i % 8] = miso;
            oe_bits[i] = oe;
            sck = 1'b1;
            if (cs_on_last && i == nbits - 1) cs = 1'b1;
            repeat (hp) @(negedge clk);
            sck = 1'b0;
        end
        repeat (hp) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] cmd, input logic [23:0] a, input int j, input logic bsy);
        if (cmd == 8'h9F) return j < 3 ? ID[8 * (2 - j) +: 8] : 8'h00;
        if (cmd == 8'h05) return {6'b0, wel_m, bsy};
        return mem[AW'(a + 24'(j))];
    endfunction

    task automatic trans(input logic [7:0] cmd, input logic [23:0] a, input int nbits, input bit col, input logic bsy);
        int eff, ds;
        eff = nbits - (col ? 1 : 0);
        ds = (cmd == 8'h9F || cmd == 8'h05) ? 8 : cmd == 8'h03 ? 32 : 1 << 20;
        if (eff < 8) ds = 1 << 20;
        hp = int'($urandom_range(4, 6));
        busy = bsy;
        tx[0] = cmd;
        tx[1] = a[23:16];
        tx[2] = a[15:8];
        tx[3] = a[7:0];
        for (int k = 4; k < 16; k++) tx[k] = 8'($urandom);
        if (cmd == 8'h03 && eff >= 32)
            for (int k = 0; k <= (eff - 32) / 8; k++) exp_addr_q.push_back(AW'(a + 24'(k)));
        run(nbits, col);
        for (int i = 0; i < nbits; i++) check($sformatf("oe_bit%0d_cmd%h", i, cmd), 32'(oe_bits[i]), 32'(i >= ds));
        for (int j = 0; ds + 8 * j + 8 <= nbits; j++)
            check($sformatf("rx_byte%0d_cmd%h", j, cmd), 32'(rx[ds / 8 + j]), 32'(exp_byte(cmd, a, j, bsy)));
        check("strobes_done", 32'(exp_addr_q.size()), 32'd0);
        exp_addr_q.delete();
        if ((cmd == 8'h06 || cmd == 8'h04) && nbits == 8) wel_m = cmd == 8'h06;
    endtask

    task automatic random_trans();
        int r, nb;
        bit col;
        logic [7:0] cmd;
        logic [23:0] a;
        r = int'($urandom_range(0, 5));
        cmd = r == 0 ? 8'h9F : r == 1 ? 8'h05 : r == 2 ? 8'h03 : r == 3 ? 8'h06 : r == 4 ? 8'h04 : others[$urandom_range(0, 4)];
        a = 24'($urandom);
        if ($urandom_range(0, 3) == 0) a[15:0] = 16'hFFFE + 16'($urandom_range(0, 1));
        col = 1'b0;
        case (r)
            0, 1: nb = 8 + 8 * int'($urandom_range(0, 4)) + ($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 7)) : 0);
            2: begin
                nb = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 40)) : 32 + 8 * int'($urandom_range(1, 4));
                col = nb >= 40 && $urandom_range(0, 1) == 1;
            end
            3, 4: nb = $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 16)) : 8;
            default: nb = int'($urandom_range(1, 24));
        endcase
        trans(cmd, a, nb, col, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int c0;
        for (int k = 0; k < 65536; k++) mem[k] = 8'($urandom);
        repeat (4) @(negedge clk);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        trans(8'h9F, 24'h0, 40, 0, 1'b0);
        check("lit_id0", 32'(rx[1]), 32'hEF);
        check("lit_id1", 32'(rx[2]), 32'h40);
        check("lit_id2", 32'(rx[3]), 32'h16);
        check("lit_id3", 32'(rx[4]), 32'h00);

        mem[16'h1234] = 8'hA5;
        mem[16'h1235] = 8'h5A;
        c0 = rd_cnt;
        trans(8'h03, 24'h001234, 48, 1, 1'b0);
        check("lit_rd0", 32'(rx[4]), 32'hA5);
        check("lit_rd1", 32'(rx[5]), 32'h5A);
        check("lit_rd_strobes", 32'(rd_cnt - c0), 32'd2);

        c0 = rd_cnt;
        trans(8'h03, 24'h00FFFF, 56, 1, 1'b0);
        check("lit_wrap_strobes", 32'(rd_cnt - c0), 32'd3);
        trans(8'h03, 24'hC3FFFF, 56, 0, 1'b0);

        trans(8'h06, 24'h0, 8, 0, 1'b1);
        trans(8'h05, 24'h0, 16, 0, 1'b1);
        check("lit_stat_wel", 32'(rx[1]), 32'h03);
        trans(8'h04, 24'h0, 5, 0, 1'b1);
        trans(8'h05, 24'h0, 24, 0, 1'b1);
        check("lit_stat_short_wrdi", 32'(rx[1]), 32'h03);
        trans(8'h04, 24'h0, 8, 0, 1'b1);
        trans(8'h05, 24'h0, 16, 0, 1'b1);
        check("lit_stat_wrdi", 32'(rx[1]), 32'h01);

        c0 = rd_cnt;
        trans(8'h03, 24'h001234, 12, 0, 1'b0);
        check("lit_abort_strobes", 32'(rd_cnt - c0), 32'd0);
        trans(8'h9F, 24'h0, 16, 0, 1'b0);
        check("lit_after_abort", 32'(rx[1]), 32'hEF);

        trans(8'h06, 24'h0, 8, 0, 1'b0);
        tx[0] = 8'h9F;
        for (int k = 1; k < 16; k++) tx[k] = 8'h00;
        hp = 5;
        busy = 1'b0;
        fork
            run(40, 0);
            begin
                repeat (150) @(negedge clk);
                check("oe_before_reset", 32'(oe), 32'd1);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check("oe_after_reset", 32'(oe), 32'd0);
            end
        join
        wel_m = 0;
        trans(8'h05, 24'h0, 16, 0, 1'b0);
        check("lit_stat_after_reset", 32'(rx[1]), 32'h00);

        for (int n = 0; n < 30; n++) random_trans();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
